// File: rtl/arbiter8way_pkg.sv
// arbiter8way_pkg: shared definitions for the 8-way round-robin arbiter.
//   ARB_N / ARB_IDX_W : requester count and index width
//   arb_state_e       : FSM state encoding (IDLE / GRANT)
//   arb_dbg_t         : debug view of the arbiter's internal state
//   onehot8()         : index -> one-hot helper
package arbiter8way_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e           state;
    logic [ARB_IDX_W-1:0] ptr;
    logic [7:0]           hold_cnt;
  } arb_dbg_t;

  function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDX_W-1:0] idx);
    onehot8 = {{(ARB_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/arbiter8way_rr_pick8.sv
// rr_pick8: combinational round-robin priority pick over 8 requesters.
//   req : request vector
//   ptr : index with highest priority; priority falls off ptr, ptr+1, ... (mod 8)
//   any : at least one request present
//   idx : winning index (0 when any=0)
module rr_pick8
  import arbiter8way_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic                 any,
  output logic [ARB_IDX_W-1:0] idx
);

  logic [ARB_IDX_W-1:0] cand;

  // Scan from lowest priority to highest so the highest-priority hit
  // is the one left standing.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      cand = ptr + ARB_IDX_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/arbiter8way.sv
// arbiter8way: round-robin arbiter sharing one resource among 8 requesters.
// Grants are held until the owner asserts done or withdraws its request;
// the next grant is handed over on the same edge, without an idle cycle.
// Optional macro ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset
//   req     : request vector, bit i = requester i
//   done    : owner finished (only looked at while busy)
//   grant   : registered one-hot grant, zero when idle
//   sel     : registered binary index of the owner (feeds dmux8way/mux8way)
//   busy    : a grant is active
//   timeout : one-cycle pulse after a forced release (0 without ARB_TIMEOUT_EN)
//   dbg_o   : FSM state, priority pointer and hold counter
//
// Handshake: a requester holds req[i] high until it sees grant[i] and keeps
// it high for as long as it wants the resource; it ends ownership by pulsing
// done or by dropping req[i]. The owner loses the grant on the edge that
// samples either event.
module arbiter8way
  import arbiter8way_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ARB_N-1:0]     req,
  input  logic                 done,
  output logic [ARB_N-1:0]     grant,
  output logic [ARB_IDX_W-1:0] sel,
  output logic                 busy,
  output logic                 timeout,
  output arb_dbg_t             dbg_o
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arbiter8way: MAX_HOLD must be in 2..255");
  end

  arb_state_e           state_q, state_d;
  logic [ARB_N-1:0]     grant_q, grant_d;
  logic [ARB_IDX_W-1:0] sel_q, sel_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic                 timeout_q, timeout_d;

  logic                 owner_req;
  logic                 force_rel;
  logic                 release_now;
  logic [ARB_IDX_W-1:0] ptr_next;
  logic [ARB_N-1:0]     pick_req;
  logic [ARB_IDX_W-1:0] pick_ptr;
  logic                 pick_any;
  logic [ARB_IDX_W-1:0] pick_idx;

  assign owner_req   = req[sel_q];
  assign ptr_next    = sel_q + 3'd1;
  assign release_now = (state_q == ARB_GRANT) && (done || !owner_req || force_rel);

  // One picker serves both cases: from IDLE it scans the raw requests from
  // ptr; during GRANT it scans the other requesters from the post-release
  // pointer, so a handover never selects the outgoing owner.
  assign pick_req = (state_q == ARB_GRANT) ? (req & ~onehot8(sel_q)) : req;
  assign pick_ptr = (state_q == ARB_GRANT) ? ptr_next : ptr_q;

  rr_pick8 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign force_rel = (hold_q == 8'(MAX_HOLD - 1));

  // Count restarts on every new or renewed grant and stays 0 while idle.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ARB_IDLE || release_now) begin
      hold_d = 8'd0;
    end else if (hold_q != 8'hFF) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign dbg_o.hold_cnt = hold_q;
`else
  assign force_rel      = 1'b0;
  assign dbg_o.hold_cnt = 8'd0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        sel_d   = '0;
        if (pick_any) begin
          state_d = ARB_GRANT;
          grant_d = onehot8(pick_idx);
          sel_d   = pick_idx;
        end
      end
      ARB_GRANT: begin
        if (release_now) begin
          ptr_d = ptr_next;
          // Only report a timeout when nothing else would have released.
          timeout_d = force_rel && !done && owner_req;
          if (pick_any) begin
            grant_d = onehot8(pick_idx);
            sel_d   = pick_idx;
          end else if (owner_req) begin
            grant_d = onehot8(sel_q);
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign busy        = (state_q == ARB_GRANT);
  assign timeout     = timeout_q;
  assign dbg_o.state = state_q;
  assign dbg_o.ptr   = ptr_q;

endmodule

// File: tb/tb_arbiter8way.sv
// tb_arbiter8way: self-checking bench for arbiter8way.
// A behavioural reference model pushes the expected {timeout,busy,sel,grant}
// for every driven cycle into exp_q; each test pops and compares after the
// clock edge, and also checks directed constants for its scenario.
module tb_arbiter8way;
  import arbiter8way_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  localparam int W = 13;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;
  arb_dbg_t   dbg;

  always #5 clk = ~clk;

  arbiter8way #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout),
    .dbg_o   (dbg)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  int m_sel, m_ptr, m_hold;
  bit m_busy, m_to;

  function automatic int m_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_ptr = 0; m_hold = 0; m_busy = 0; m_to = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int  w;
    bit  frc, own;
    logic [7:0] g;
    m_to = 0;
    if (!m_busy) begin
      w = m_pick(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_sel = w; m_hold = 0;
      end
    end else begin
      frc = TO_EN && (m_hold == MH - 1);
      own = r[m_sel];
      if (d || !own || frc) begin
        m_to  = frc && !d && own;
        m_ptr = (m_sel + 1) % 8;
        w = m_pick(r & ~(8'b1 << m_sel), m_ptr);
        if (w >= 0) begin
          m_sel = w; m_hold = 0;
        end else if (own) begin
          m_hold = 0;
        end else begin
          m_busy = 0; m_sel = 0; m_hold = 0;
        end
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
    g = m_busy ? (8'b1 << m_sel) : 8'h00;
    exp_q.push_back({m_to, m_busy, 3'(m_sel), g});
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; inputs are sampled on the next edge and outputs
  // are observed 1 time unit after it.
  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    do_reset();
    step(8'h20, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({timeout, busy, sel, grant} !== e || sel !== 3'd5) begin
      failures++;
      $display("FAIL reset_pre_owner5 got=%h exp=%h", {timeout, busy, sel, grant}, e);
    end
    // Async reset mid-grant, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got g=%h s=%0d b=%b t=%b exp all 0", grant, sel, busy, timeout);
    end
    checks++;
    if (dbg.state !== ARB_IDLE || dbg.ptr !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got st=%b ptr=%0d exp st=0 ptr=0", dbg.state, dbg.ptr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== 8'h00 || dbg.ptr !== 3'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d] got=%h ptr=%0d exp=%h ptr=0", i, {timeout, busy, sel, grant}, dbg.ptr, e);
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] e;
    logic [7:0]   rq[4] = '{8'h10, 8'h10, 8'h10, 8'h00};
    logic         dn[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]   eg[4] = '{8'h10, 8'h10, 8'h10, 8'h00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(rq[i], dn[i]);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== eg[i] || busy !== (eg[i] != 8'h00)) begin
        failures++;
        $display("FAIL single[%0d] got=%h g=%h exp=%h g=%h", i, {timeout, busy, sel, grant}, grant, e, eg[i]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || sel !== 3'(i % 8) || busy !== 1'b1) begin
        failures++;
        $display("FAIL rotation[%0d] got sel=%0d busy=%b exp sel=%0d busy=1", i, sel, busy, i % 8);
      end
    end
    step(8'h00, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if ({timeout, busy, sel, grant} !== e || busy !== 1'b0) begin
      failures++;
      $display("FAIL rotation_end got=%h exp=%h", {timeout, busy, sel, grant}, e);
    end
  endtask

  task automatic test_withdraw();
    logic [W-1:0] e;
    logic [7:0]   rq[4] = '{8'h84, 8'h80, 8'h84, 8'h00};
    logic         dn[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]   eg[4] = '{8'h04, 8'h80, 8'h04, 8'h00};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(rq[i], dn[i]);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== eg[i]) begin
        failures++;
        $display("FAIL withdraw[%0d] got=%h g=%h exp=%h g=%h", i, {timeout, busy, sel, grant}, grant, e, eg[i]);
      end
    end
  endtask

  task automatic test_sole_regrant();
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(8'h08, (i > 0) && (i % 2 == 0));
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== 8'h08 || busy !== 1'b1) begin
        failures++;
        $display("FAIL sole[%0d] got g=%h b=%b exp g=08 b=1", i, grant, busy);
      end
    end
    checks++;
    if (dbg.ptr !== 3'd4) begin
      failures++;
      $display("FAIL sole_ptr got=%0d exp=4", dbg.ptr);
    end
    step(8'h00, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({timeout, busy, sel, grant} !== e || busy !== 1'b0) begin
      failures++;
      $display("FAIL sole_end got=%h exp=%h", {timeout, busy, sel, grant}, e);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] e;
    logic [7:0]   eg;
    logic         et;
    do_reset();
    step(8'h02, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({timeout, busy, sel, grant} !== e || grant !== 8'h02) begin
      failures++;
      $display("FAIL timeout_grant got g=%h exp g=02", grant);
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 5; i++) begin
      step(8'h42, 1'b0);
      eg = (i >= 4) ? 8'h40 : 8'h02;
      et = (i == 4);
      e  = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== eg || timeout !== et) begin
        failures++;
        $display("FAIL timeout[%0d] got g=%h t=%b exp g=%h t=%b", i, grant, timeout, eg, et);
      end
    end
`else
    eg = 8'h02;
    et = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step(8'h42, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || grant !== eg || timeout !== et) begin
        failures++;
        $display("FAIL hold[%0d] got g=%h t=%b exp g=%h t=%b", i, grant, timeout, eg, et);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [7:0]   r;
    logic         d;
    do_reset();
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      d = ($urandom_range(0, 4) == 0);
      step(r, d);
      e = exp_q.pop_front();
      checks++;
      if ({timeout, busy, sel, grant} !== e || !$onehot0(grant)) begin
        failures++;
        $display("FAIL random[%0d] req=%h done=%b got=%h exp=%h", i, r, d, {timeout, busy, sel, grant}, e);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_withdraw();
    test_sole_regrant();
    test_timeout();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d entries exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
